// File: rtl/lmdpl_pkg.sv
// Shared definitions for the LMDPL masked gate family: phase encodings, stage
// encoding and the NAND mask-table function used to build the evaluation table.
package lmdpl_pkg;

    localparam logic PRECHARGE = 1'b1;
    localparam logic EVALUATE  = 1'b0;

    localparam logic [31:0] XS_SEED = 32'h2545_F491;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_EVAL = 2'd2
    } stage_e;

    // Entry {i1,i0} holds the masked true-rail value for masked operands a=i1, b=i0.
    function automatic logic [3:0] lmdpl_table(input logic m0, input logic m1, input logic mo);
        logic [3:0] t;
        logic [1:0] idx;
        t = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            idx  = 2'(i);
            t[i] = ~((idx[1] ^ m0) & (idx[0] ^ m1)) ^ mo;
        end
        return t;
    endfunction

endpackage

// File: rtl/lmdpl_mask_table.sv
// Combinational NAND mask table: maps the latched mask bits to the 4-entry
// lookup that the one-hot selector indexes during evaluation.
module lmdpl_mask_table
    import lmdpl_pkg::*;
(
    input  logic       i_m0,
    input  logic       i_m1,
    input  logic       i_mo,
    output logic [3:0] o_table
);

    assign o_table = lmdpl_table(i_m0, i_m1, i_mo);

endmodule

// File: rtl/lmdpl_xorshift32.sv
// 32-bit xorshift PRNG supplying mask bits; the seed is nonzero so the state
// can never collapse to zero.
module lmdpl_xorshift32
    import lmdpl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rng_out
);

    logic [31:0] r_state;
    logic [31:0] w_x1;
    logic [31:0] w_x2;
    logic [31:0] w_x3;

    assign w_x1 = r_state ^ (r_state << 13);
    assign w_x2 = w_x1 ^ (w_x1 >> 17);
    assign w_x3 = w_x2 ^ (w_x2 << 5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= XS_SEED;
        end else begin
            r_state <= w_x3;
        end
    end

    assign rng_out = r_state;

endmodule

// File: rtl/lmdpl_nand_gate.sv
// Sequential LMDPL 2-input NAND: operands are held only in masked form, the
// dual-rail pair is built from registers, and the result is unmasked on output.
module lmdpl_nand_gate (
    input  logic clk,
    input  logic rst_n,
    input  logic precharge,
    input  logic in0,
    input  logic in1,
    input  logic m_in0,
    input  logic m_in1,
    input  logic m_out,
    output logic out
);

    import lmdpl_pkg::*;

    stage_e     r_state;
    stage_e     w_state_nxt;
    logic       r_am;
    logic       r_bm;
    logic       r_m0;
    logic       r_m1;
    logic       r_mo;
    logic [3:0] r_oh;
    logic [3:0] r_t;
    logic [3:0] w_table;
    logic       w_y_t;
    logic       w_y_f;
    logic       r_out;

    lmdpl_mask_table u_mask_table (
        .i_m0    (r_m0),
        .i_m1    (r_m1),
        .i_mo    (r_mo),
        .o_table (w_table)
    );

    // NOTE: every register here is reset, including out, so a reset mid-operation
    // leaves no trace of the previous operands or masks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignment so all state updates see pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Evaluation only starts from S_PRE, so evaluate edges after reset with no
    // precharge leave the rails cleared and out untouched.
    always_comb begin
        // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        if (precharge == PRECHARGE) begin
            w_state_nxt = S_PRE;
        end else begin
            case (r_state)
                S_PRE:   w_state_nxt = S_EVAL;
                S_EVAL:  w_state_nxt = S_EVAL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_am  <= 1'b0;
            r_bm  <= 1'b0;
            r_m0  <= 1'b0;
            r_m1  <= 1'b0;
            r_mo  <= 1'b0;
            r_oh  <= 4'b0000;
            r_t   <= 4'b0000;
            r_out <= 1'b0;
        end else if (precharge == PRECHARGE) begin
            r_am <= in0 ^ m_in0;
            r_bm <= in1 ^ m_in1;
            r_m0 <= m_in0;
            r_m1 <= m_in1;
            r_mo <= m_out;
            r_oh <= 4'b0000;
            r_t  <= 4'b0000;
        end else if (r_state == S_PRE) begin
            r_oh <= 4'b0001 << {r_am, r_bm};
            r_t  <= w_table;
        end else if (r_state == S_EVAL) begin
            // Only a complementary rail pair may update out.
            if ((w_y_t ^ w_y_f) == 1'b1) begin
                r_out <= w_y_t ^ r_mo;
            end
        end
    end

    assign w_y_t = |(r_oh & r_t);
    assign w_y_f = |(r_oh & ~r_t);
    assign out   = r_out;

endmodule

// File: tb/tb_lmdpl_nand_gate.sv
// Directed bench for the LMDPL NAND gate: reset, latency, mask sweep, reset
// mid-evaluation, operand isolation and precharge abort; masks partly from the PRNG.
module tb_lmdpl_nand_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rng_rst_n;
    logic        precharge;
    logic        in0;
    logic        in1;
    logic        m_in0;
    logic        m_in1;
    logic        m_out;
    logic        out;
    logic [31:0] rng_out;
    logic [31:0] rng_model;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    lmdpl_nand_gate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .precharge (precharge),
        .in0       (in0),
        .in1       (in1),
        .m_in0     (m_in0),
        .m_in1     (m_in1),
        .m_out     (m_out),
        .out       (out)
    );

    lmdpl_xorshift32 u_rng (
        .clk     (clk),
        .rst_n   (rng_rst_n),
        .rng_out (rng_out)
    );

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // One rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        if (rng_rst_n) rng_model = xs_next(rng_model);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full precharge + two evaluate edges, checking rails and result.
    task automatic run_op(input logic a, input logic b, input logic m0, input logic m1,
                          input logic mo, input string tag);
        logic exp_out;
        logic exp_yt;
        exp_out   = ~(a & b);
        exp_yt    = exp_out ^ mo;
        precharge = 1'b1;
        in0 = a; in1 = b; m_in0 = m0; m_in1 = m1; m_out = mo;
        step();
        check({tag, ".rails_pre"}, {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);
        precharge = 1'b0;
        step();
        check({tag, ".rails_ev1"}, {30'd0, dut.w_y_t, dut.w_y_f}, {30'd0, exp_yt, ~exp_yt});
        step();
        check({tag, ".out"}, {31'd0, out}, {31'd0, exp_out});
    endtask

    initial begin
        rst_n = 1'b0; rng_rst_n = 1'b0; rng_model = 32'h2545_F491;
        precharge = 1'b0; in0 = 1'b0; in1 = 1'b0;
        m_in0 = 1'b0; m_in1 = 1'b0; m_out = 1'b0;
        step();
        step();

        // Reset state
        check("reset.out", {31'd0, out}, 32'd0);
        check("reset.rails", {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);
        check("reset.rng", rng_out, 32'h2545_F491);
        rst_n = 1'b1; rng_rst_n = 1'b1;

        // T1: zero masks, 0 NAND 0, latency of two evaluate edges
        precharge = 1'b1; in0 = 1'b0; in1 = 1'b0;
        step();
        check("t1.rails_pre", {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);
        precharge = 1'b0;
        step();
        check("t1.rails_ev1", {30'd0, dut.w_y_t, dut.w_y_f}, 32'b10);
        check("t1.out_ev1", {31'd0, out}, 32'd0);
        step();
        check("t1.out_ev2", {31'd0, out}, 32'd1);
        step();
        check("t1.out_ev3", {31'd0, out}, 32'd1);
        check("t1.rng", rng_out, rng_model);

        // T2/T3: PRNG-supplied masks
        run_op(1'b0, 1'b1, rng_out[0], rng_out[1], rng_out[2], "t2.a");
        run_op(1'b1, 1'b0, rng_out[0], rng_out[1], rng_out[2], "t2.b");
        run_op(1'b1, 1'b1, rng_out[0], rng_out[1], rng_out[2], "t3");
        check("t3.rng", rng_out, rng_model);
        check("t3.rng_nonzero", {31'd0, rng_out != 32'd0}, 32'd1);

        // T4: every mask combination against every operand pair
        for (int m = 0; m < 8; m++) begin
            for (int v = 0; v < 4; v++) begin
                run_op(v[1], v[0], m[0], m[1], m[2], $sformatf("t4.m%0d.v%0d", m, v));
            end
        end

        // T5: reset mid-evaluation clears out immediately
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "t5.pre");
        precharge = 1'b1; in0 = 1'b0; in1 = 1'b1;
        step();
        precharge = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("t5.out_async", {31'd0, out}, 32'd0);
        check("t5.rails_async", {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);
        rst_n = 1'b1;
        in0 = 1'b0; in1 = 1'b0; m_in0 = 1'b0; m_in1 = 1'b0; m_out = 1'b0;
        step();
        step();
        step();
        check("t5.no_pre_out", {31'd0, out}, 32'd0);
        check("t5.no_pre_rails", {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);

        // T6: operand changes during evaluate are ignored
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t6.pre");
        precharge = 1'b1; in0 = 1'b1; in1 = 1'b1; m_in0 = 1'b1; m_in1 = 1'b0; m_out = 1'b0;
        step();
        precharge = 1'b0; in0 = 1'b0; in1 = 1'b0; m_in0 = 1'b0; m_in1 = 1'b1; m_out = 1'b1;
        step();
        step();
        check("t6.captured", {31'd0, out}, 32'd0);

        // T6: precharge re-asserted after evaluate edge 1 aborts and out holds
        precharge = 1'b1; in0 = 1'b0; in1 = 1'b0;
        step();
        precharge = 1'b0;
        step();
        check("t6.abort_rails_ev1", {30'd0, dut.w_y_t, dut.w_y_f}, 32'b01);
        precharge = 1'b1;
        step();
        check("t6.abort_out", {31'd0, out}, 32'd0);
        check("t6.abort_rails", {30'd0, dut.w_y_t, dut.w_y_f}, 32'd0);
        step();
        check("t6.abort_out2", {31'd0, out}, 32'd0);
        precharge = 1'b0;
        step();
        step();
        check("t6.resume_out", {31'd0, out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
